// File: rtl/axis_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream width converter.
package axis_pkg;

    // Largest supported width ratio; sizes the beat counter type.
    localparam int MAX_RATIO = 256;

    // Beat / sub-beat counter, one bit wider than log2 of the ratio.
    typedef logic [$clog2(MAX_RATIO):0] beat_cnt_t;

    typedef enum logic [1:0] {
        AXW_PASS,
        AXW_UP,
        AXW_DOWN
    } axw_mode_e;

    // Ratio of the wider to the narrower side.
    function automatic int ratio(input int in_b, input int out_b);
        return (in_b >= out_b) ? (in_b / out_b) : (out_b / in_b);
    endfunction

    // Conversion mode from the two byte widths.
    function automatic axw_mode_e mode_sel(input int in_b, input int out_b);
        if (in_b == out_b) return AXW_PASS;
        if (in_b < out_b)  return AXW_UP;
        return AXW_DOWN;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output holding register with valid flag. The owner decides when a new
// word is loaded and when the held word leaves; a load wins over a pop so
// that a same-edge drain and refill keeps valid high.
module axis_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          pop,
    input  logic [DW-1:0] in_data,
    input  logic [KW-1:0] in_keep,
    input  logic          in_last,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [KW-1:0] keep,
    output logic          last
);

    // Capture a new word on load, drop valid when the held word is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            keep  <= in_keep;
            last  <= in_last;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_width_conv.sv
// AXI-Stream width converter: pass-through slice, little-endian packer
// (upsize) or splitter (downsize), chosen from the two byte widths.
module axis_width_conv
    import axis_pkg::*;
#(
    parameter int  INPUT_BYTES  = 4,
    parameter int  OUTPUT_BYTES = 4,
    localparam int IW           = INPUT_BYTES * 8,
    localparam int OW           = OUTPUT_BYTES * 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [IW-1:0]           axis_s_data_i,
    input  logic                    axis_s_valid_i,
    output logic                    axis_s_ready_o,
    input  logic                    axis_s_last_i,
    output logic [OW-1:0]           axis_m_data_o,
    output logic                    axis_m_valid_o,
    input  logic                    axis_m_ready_i,
    output logic                    axis_m_last_o,
    output logic [OUTPUT_BYTES-1:0] axis_m_keep_o
);

    localparam axw_mode_e MODE = mode_sel(INPUT_BYTES, OUTPUT_BYTES);
    localparam int        N    = ratio(INPUT_BYTES, OUTPUT_BYTES);

    if (((INPUT_BYTES > OUTPUT_BYTES) ? (INPUT_BYTES % OUTPUT_BYTES)
                                      : (OUTPUT_BYTES % INPUT_BYTES)) != 0) begin : g_bad_ratio
        $fatal(1, "axis_width_conv: wider side must be a multiple of the narrower side");
    end
    if (N > MAX_RATIO) begin : g_bad_size
        $fatal(1, "axis_width_conv: width ratio exceeds MAX_RATIO");
    end

    if (MODE == AXW_PASS) begin : g_pass
        logic load;

        assign axis_s_ready_o = !rst_i && (!axis_m_valid_o || axis_m_ready_i);
        assign load           = axis_s_valid_i && axis_s_ready_o;

        axis_out_reg #(.DW(OW), .KW(OUTPUT_BYTES)) u_out (
            .clk     (clk_i),
            .rst     (rst_i),
            .load    (load),
            .pop     (axis_m_ready_i),
            .in_data (axis_s_data_i),
            .in_keep ({OUTPUT_BYTES{1'b1}}),
            .in_last (axis_s_last_i),
            .valid   (axis_m_valid_o),
            .data    (axis_m_data_o),
            .keep    (axis_m_keep_o),
            .last    (axis_m_last_o)
        );

    end else if (MODE == AXW_UP) begin : g_up
        localparam beat_cnt_t LAST_IDX = beat_cnt_t'(N - 1);

        logic [OW-1:0]           acc_data;
        logic [OUTPUT_BYTES-1:0] acc_keep;
        logic [OW-1:0]           word_data;
        logic [OUTPUT_BYTES-1:0] word_keep;
        beat_cnt_t               cnt;
        logic                    closing;
        logic                    accept;

        // Current beat would finish a word: either the last slot or an early close.
        assign closing        = axis_s_last_i || (cnt == LAST_IDX);
        // Only a completing beat needs the output register; stall it if that is still occupied.
        assign axis_s_ready_o = !rst_i && !(closing && axis_m_valid_o && !axis_m_ready_i);
        assign accept         = axis_s_valid_i && axis_s_ready_o;

        // Merge the incoming beat into the partial word; unfilled bytes stay zero.
        always_comb begin
            word_data                                   = acc_data;
            word_keep                                   = acc_keep;
            word_data[cnt*IW +: IW]                     = axis_s_data_i;
            word_keep[cnt*INPUT_BYTES +: INPUT_BYTES]   = {INPUT_BYTES{1'b1}};
        end

        // Accumulate beats; a completed word hands off and the packer restarts at byte 0.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_data <= '0;
                acc_keep <= '0;
                cnt      <= '0;
            end else if (accept) begin
                if (closing) begin
                    acc_data <= '0;
                    acc_keep <= '0;
                    cnt      <= '0;
                end else begin
                    acc_data <= word_data;
                    acc_keep <= word_keep;
                    cnt      <= cnt + beat_cnt_t'(1);
                end
            end
        end

        axis_out_reg #(.DW(OW), .KW(OUTPUT_BYTES)) u_out (
            .clk     (clk_i),
            .rst     (rst_i),
            .load    (accept && closing),
            .pop     (axis_m_ready_i),
            .in_data (word_data),
            .in_keep (word_keep),
            .in_last (axis_s_last_i),
            .valid   (axis_m_valid_o),
            .data    (axis_m_data_o),
            .keep    (axis_m_keep_o),
            .last    (axis_m_last_o)
        );

    end else begin : g_down
        localparam beat_cnt_t LAST_IDX = beat_cnt_t'(N - 1);

        logic [IW-1:0] hold_data;
        logic          hold_last;
        logic          on_last_sub;
        logic          load;
        beat_cnt_t     idx;

        assign on_last_sub    = (idx == LAST_IDX);
        // Refill only when empty or when the final sub-beat leaves on this edge.
        assign axis_s_ready_o = !rst_i && (!axis_m_valid_o || (axis_m_ready_i && on_last_sub));
        assign load           = axis_s_valid_i && axis_s_ready_o;
        assign axis_m_data_o  = hold_data[idx*OW +: OW];
        assign axis_m_last_o  = hold_last && on_last_sub;

        // Step through sub-beats of the held word; a fresh word starts at sub-beat 0.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                idx <= '0;
            end else if (load) begin
                idx <= '0;
            end else if (axis_m_valid_o && axis_m_ready_i) begin
                idx <= on_last_sub ? '0 : idx + beat_cnt_t'(1);
            end
        end

        axis_out_reg #(.DW(IW), .KW(OUTPUT_BYTES)) u_out (
            .clk     (clk_i),
            .rst     (rst_i),
            .load    (load),
            .pop     (axis_m_ready_i && on_last_sub),
            .in_data (axis_s_data_i),
            .in_keep ({OUTPUT_BYTES{1'b1}}),
            .in_last (axis_s_last_i),
            .valid   (axis_m_valid_o),
            .data    (hold_data),
            .keep    (axis_m_keep_o),
            .last    (hold_last)
        );
    end

endmodule

// File: tb/tb_axis_width_conv.sv
// Bench for axis_width_conv: upsize 1->4, downsize 4->1 and pass 4->4 instances.
module tb_axis_width_conv;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // upsize IB=1 OB=4
    logic [7:0]  u_s_data;
    logic        u_s_valid, u_s_ready, u_s_last;
    logic [31:0] u_m_data;
    logic        u_m_valid, u_m_ready, u_m_last;
    logic [3:0]  u_m_keep;
    // downsize IB=4 OB=1
    logic [31:0] d_s_data;
    logic        d_s_valid, d_s_ready, d_s_last;
    logic [7:0]  d_m_data;
    logic        d_m_valid, d_m_ready, d_m_last;
    logic [0:0]  d_m_keep;
    // pass IB=OB=4
    logic [31:0] p_s_data;
    logic        p_s_valid, p_s_ready, p_s_last;
    logic [31:0] p_m_data;
    logic        p_m_valid, p_m_ready, p_m_last;
    logic [3:0]  p_m_keep;

    axis_width_conv #(.INPUT_BYTES(1), .OUTPUT_BYTES(4)) u_up (
        .clk_i(clk), .rst_i(rst),
        .axis_s_data_i(u_s_data), .axis_s_valid_i(u_s_valid), .axis_s_ready_o(u_s_ready),
        .axis_s_last_i(u_s_last), .axis_m_data_o(u_m_data), .axis_m_valid_o(u_m_valid),
        .axis_m_ready_i(u_m_ready), .axis_m_last_o(u_m_last), .axis_m_keep_o(u_m_keep));

    axis_width_conv #(.INPUT_BYTES(4), .OUTPUT_BYTES(1)) u_dn (
        .clk_i(clk), .rst_i(rst),
        .axis_s_data_i(d_s_data), .axis_s_valid_i(d_s_valid), .axis_s_ready_o(d_s_ready),
        .axis_s_last_i(d_s_last), .axis_m_data_o(d_m_data), .axis_m_valid_o(d_m_valid),
        .axis_m_ready_i(d_m_ready), .axis_m_last_o(d_m_last), .axis_m_keep_o(d_m_keep));

    axis_width_conv #(.INPUT_BYTES(4), .OUTPUT_BYTES(4)) u_ps (
        .clk_i(clk), .rst_i(rst),
        .axis_s_data_i(p_s_data), .axis_s_valid_i(p_s_valid), .axis_s_ready_o(p_s_ready),
        .axis_s_last_i(p_s_last), .axis_m_data_o(p_m_data), .axis_m_valid_o(p_m_valid),
        .axis_m_ready_i(p_m_ready), .axis_m_last_o(p_m_last), .axis_m_keep_o(p_m_keep));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({u_m_valid, u_m_last, u_m_keep, u_m_data, u_s_ready} !== 39'd0) begin
            errors++; $display("FAIL reset_up got v%b l%b k%h d%h r%b want all 0", u_m_valid, u_m_last, u_m_keep, u_m_data, u_s_ready);
        end
        checks++;
        if ({d_m_valid, d_m_last, d_m_keep, d_m_data, d_s_ready} !== 12'd0) begin
            errors++; $display("FAIL reset_dn got v%b l%b k%h d%h r%b want all 0", d_m_valid, d_m_last, d_m_keep, d_m_data, d_s_ready);
        end
        checks++;
        if ({p_m_valid, p_m_last, p_m_keep, p_m_data, p_s_ready} !== 39'd0) begin
            errors++; $display("FAIL reset_ps got v%b l%b k%h d%h r%b want all 0", p_m_valid, p_m_last, p_m_keep, p_m_data, p_s_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_s_ready, d_s_ready, p_s_ready} !== 3'b111) begin
            errors++; $display("FAIL ready_after_reset got %b want 111", {u_s_ready, d_s_ready, p_s_ready});
        end
        tick();
    endtask

    task automatic test_up_full();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        u_m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            u_s_valid = 1'b1; u_s_data = b[k]; u_s_last = (k == 3);
            @(negedge clk);
            checks++;
            if ({u_s_ready, u_m_valid} !== 2'b10) begin
                errors++; $display("FAIL up_full_beat%0d got rdy%b vld%b want rdy1 vld0", k, u_s_ready, u_m_valid);
            end
            tick();
        end
        u_s_valid = 1'b0; u_s_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_m_valid, u_m_last, u_m_keep, u_m_data} !== {1'b1, 1'b1, 4'hF, 32'h44332211}) begin
            errors++; $display("FAIL up_full_word got v%b l%b k%h d%h want v1 l1 kF d44332211", u_m_valid, u_m_last, u_m_keep, u_m_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (u_m_valid !== 1'b0) begin
            errors++; $display("FAIL up_full_drain got v%b want 0", u_m_valid);
        end
        tick();
    endtask

    task automatic test_up_early_close();
        logic [7:0]  b [5]   = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03};
        logic        l [5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [36:0] exp [2] = '{{1'b1, 4'h3, 32'h0000BBAA}, {1'b1, 4'h7, 32'h00030201}};
        int nout = 0;
        u_m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            u_s_valid = (c < 5);
            u_s_data  = (c < 5) ? b[c] : 8'h00;
            u_s_last  = (c < 5) ? l[c] : 1'b0;
            @(negedge clk);
            if (u_m_valid) begin
                checks++;
                if (nout > 1) begin
                    errors++; $display("FAIL up_early_extra got %h want none", u_m_data);
                end else if ({u_m_last, u_m_keep, u_m_data} !== exp[nout]) begin
                    errors++; $display("FAIL up_early_word%0d got %h want %h", nout, {u_m_last, u_m_keep, u_m_data}, exp[nout]);
                end
                nout++;
            end
            tick();
        end
        checks++;
        if (nout != 2) begin
            errors++; $display("FAIL up_early_count got %0d want 2", nout);
        end
    endtask

    task automatic test_up_backpressure();
        int sent = 0;
        logic exp_rdy;
        for (int c = 0; c < 12; c++) begin
            u_m_ready = (c >= 10);
            u_s_valid = (sent < 8);
            u_s_data  = 8'(sent + 1);
            u_s_last  = 1'b0;
            @(negedge clk);
            if (u_s_valid) begin
                exp_rdy = (c < 7) || (c >= 10);
                checks++;
                if (u_s_ready !== exp_rdy) begin
                    errors++; $display("FAIL up_bp_ready_c%0d got %b want %b", c, u_s_ready, exp_rdy);
                end
            end
            if (c == 9 || c == 10) begin
                checks++;
                if ({u_m_valid, u_m_keep, u_m_data} !== {1'b1, 4'hF, 32'h04030201}) begin
                    errors++; $display("FAIL up_bp_word1_c%0d got v%b k%h d%h want v1 kF d04030201", c, u_m_valid, u_m_keep, u_m_data);
                end
            end
            if (c == 11) begin
                checks++;
                if ({u_m_valid, u_m_last, u_m_keep, u_m_data} !== {1'b1, 1'b0, 4'hF, 32'h08070605}) begin
                    errors++; $display("FAIL up_bp_word2 got v%b l%b k%h d%h want v1 l0 kF d08070605", u_m_valid, u_m_last, u_m_keep, u_m_data);
                end
            end
            if (u_s_valid && u_s_ready) sent++;
            tick();
        end
        u_s_valid = 1'b0;
        tick();
    endtask

    task automatic test_up_reset_mid_packet();
        u_m_ready = 1'b1;
        u_s_valid = 1'b1; u_s_last = 1'b0;
        u_s_data = 8'hDE; tick();
        u_s_data = 8'hAD; tick();
        u_s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (u_s_ready !== 1'b0) begin
            errors++; $display("FAIL up_rst_ready got %b want 0", u_s_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({u_m_valid, u_m_keep} !== 5'd0) begin
            errors++; $display("FAIL up_rst_valid got v%b k%h want v0 k0", u_m_valid, u_m_keep);
        end
        rst = 1'b0;
        tick();
        u_s_valid = 1'b1; u_s_data = 8'h01; u_s_last = 1'b1;
        tick();
        u_s_valid = 1'b0; u_s_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({u_m_valid, u_m_last, u_m_keep, u_m_data} !== {1'b1, 1'b1, 4'h1, 32'h00000001}) begin
            errors++; $display("FAIL up_rst_single got v%b l%b k%h d%h want v1 l1 k1 d00000001", u_m_valid, u_m_last, u_m_keep, u_m_data);
        end
        tick();
    endtask

    task automatic test_down_split();
        logic [31:0] w [2] = '{32'h04030201, 32'h08070605};
        int wi = 0, nout = 0, first = -1, lastc = -1;
        d_m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            d_s_valid = (wi < 2);
            d_s_data  = w[wi & 1];
            d_s_last  = (wi == 1);
            @(negedge clk);
            if (d_m_valid) begin
                checks++;
                if ({d_m_last, d_m_keep, d_m_data} !== {(nout == 7), 1'b1, 8'(nout + 1)}) begin
                    errors++; $display("FAIL dn_beat%0d got l%b k%b d%h want l%b k1 d%h", nout, d_m_last, d_m_keep, d_m_data, (nout == 7), 8'(nout + 1));
                end
                if (first < 0) first = c;
                lastc = c;
                nout++;
            end
            if (d_s_valid && d_s_ready) wi++;
            tick();
        end
        d_s_valid = 1'b0;
        checks++;
        if (nout != 8 || first != 1 || lastc - first != 7) begin
            errors++; $display("FAIL dn_timing got n%0d first%0d span%0d want n8 first1 span7", nout, first, lastc - first);
        end
    endtask

    task automatic test_pass_random();
        logic [32:0] exp [$];
        logic [32:0] e;
        logic [31:0] prev_data;
        logic stall_prev = 1'b0, acc_now;
        int acc = 0, cyc = 0;
        p_s_valid = 1'b0; p_m_ready = 1'b1;
        while ((acc < 1000 || exp.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (p_m_valid !== 1'b1 || p_m_data !== prev_data) begin
                    errors++; $display("FAIL ps_stall_stable got v%b d%h want v1 d%h", p_m_valid, p_m_data, prev_data);
                end
            end
            if (p_m_valid && p_m_ready) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL ps_extra got %h want none", p_m_data);
                end else begin
                    e = exp.pop_front();
                    if ({p_m_last, p_m_keep, p_m_data} !== {e[32], 4'hF, e[31:0]}) begin
                        errors++; $display("FAIL ps_data got l%b k%h d%h want l%b kF d%h", p_m_last, p_m_keep, p_m_data, e[32], e[31:0]);
                    end
                end
            end
            stall_prev = p_m_valid && !p_m_ready;
            prev_data  = p_m_data;
            acc_now    = p_s_valid && p_s_ready;
            if (acc_now) begin
                exp.push_back({p_s_last, p_s_data});
                acc++;
            end
            tick();
            if (!p_s_valid || acc_now) begin
                p_s_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
                p_s_data  = $urandom;
                p_s_last  = ($urandom_range(0, 7) == 0);
            end
            p_m_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        p_s_valid = 1'b0;
        checks++;
        if (cyc >= 20000) begin
            errors++; $display("FAIL ps_timeout got acc%0d pending%0d want 1000/0", acc, exp.size());
        end
    endtask

    task automatic test_up_random();
        logic [7:0]  cur [$];
        logic [36:0] exp [$];
        logic [36:0] e;
        logic [31:0] w, prev_data;
        logic stall_prev = 1'b0, acc_now;
        int acc = 0, cyc = 0;
        u_s_valid = 1'b0; u_m_ready = 1'b1;
        while ((acc < 600 || exp.size() != 0) && cyc < 10000) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (u_m_valid !== 1'b1 || u_m_data !== prev_data) begin
                    errors++; $display("FAIL up_stall_stable got v%b d%h want v1 d%h", u_m_valid, u_m_data, prev_data);
                end
            end
            if (u_m_valid && u_m_ready) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL up_rand_extra got %h want none", u_m_data);
                end else begin
                    e = exp.pop_front();
                    if ({u_m_last, u_m_keep, u_m_data} !== e) begin
                        errors++; $display("FAIL up_rand_word got %h want %h", {u_m_last, u_m_keep, u_m_data}, e);
                    end
                end
            end
            stall_prev = u_m_valid && !u_m_ready;
            prev_data  = u_m_data;
            acc_now    = u_s_valid && u_s_ready;
            if (acc_now) begin
                cur.push_back(u_s_data);
                acc++;
                if (u_s_last || cur.size() == 4) begin
                    w = '0;
                    for (int i = 0; i < cur.size(); i++) w[i*8 +: 8] = cur[i];
                    exp.push_back({u_s_last, 4'((1 << cur.size()) - 1), w});
                    cur.delete();
                end
            end
            tick();
            if (!u_s_valid || acc_now) begin
                u_s_valid = (acc < 600) && ($urandom_range(0, 3) != 0);
                u_s_data  = 8'($urandom);
                u_s_last  = (acc == 599) || ($urandom_range(0, 5) == 0);
            end
            u_m_ready = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        u_s_valid = 1'b0;
        checks++;
        if (cyc >= 10000 || cur.size() != 0) begin
            errors++; $display("FAIL up_rand_timeout got acc%0d pending%0d partial%0d want 600/0/0", acc, exp.size(), cur.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        u_s_data = '0; u_s_valid = 1'b0; u_s_last = 1'b0; u_m_ready = 1'b0;
        d_s_data = '0; d_s_valid = 1'b0; d_s_last = 1'b0; d_m_ready = 1'b0;
        p_s_data = '0; p_s_valid = 1'b0; p_s_last = 1'b0; p_m_ready = 1'b0;
        test_reset();
        test_up_full();
        test_up_early_close();
        test_up_backpressure();
        test_up_reset_mid_packet();
        test_down_split();
        test_pass_random();
        test_up_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
